// File: rtl/mem_request_unit.sv
// mem_request_unit: load/store initiator onto a 64-bit doubleword memory port
// Ports:
//   clk, reset (async, active-low)
//   req_*  : valid/ready request from MEM stage (write, size, signed, addr, wdata)
//   resp_* : valid/ready response (rdata extended load data, err)
//   mem_*  : doubleword port (write enable, aligned addr, write data, comb read data, err)
module mem_request_unit #(
    parameter int ADDR_W      = 64,
    parameter bit ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_write_enabled,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_w_data,
    input  logic [63:0]       mem_r_data,
    input  logic              mem_err
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t              r_state, w_next;
    logic                r_write, w_write;
    logic [1:0]          r_size, w_size;
    logic                r_signed, w_signed;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [63:0]         r_wdata, w_wdata;
    logic [63:0]         r_rdata, w_rdata;
    logic                r_err, w_err;
    logic [2:0]          w_lowmask;
    logic                w_mis;
    logic [5:0]          w_sh;
    logic [63:0]         w_rd_sh, w_ext, w_mask, w_merged;
    // Address bits that must be zero for the requested size
    assign w_lowmask = {&req_size, req_size[1], |req_size};
    assign w_mis     = |(req_addr[2:0] & w_lowmask);
    assign w_sh      = {r_addr[2:0], 3'b000};
    assign w_rd_sh   = mem_r_data >> w_sh;
    assign w_ext     = r_size == 2'd0 ? {{56{r_signed & w_rd_sh[7]}},  w_rd_sh[7:0]}  :
                       r_size == 2'd1 ? {{48{r_signed & w_rd_sh[15]}}, w_rd_sh[15:0]} :
                       r_size == 2'd2 ? {{32{r_signed & w_rd_sh[31]}}, w_rd_sh[31:0]} : w_rd_sh;
    assign w_mask    = r_size == 2'd0 ? 64'h0000_0000_0000_00FF :
                       r_size == 2'd1 ? 64'h0000_0000_0000_FFFF :
                       r_size == 2'd2 ? 64'h0000_0000_FFFF_FFFF : '1;
    // Read-modify-write: splice the store bytes into the doubleword just read
    assign w_merged  = (mem_r_data & ~(w_mask << w_sh)) | ((r_wdata & w_mask) << w_sh);
    always_comb begin
        w_next   = r_state;
        w_write  = r_write;
        w_size   = r_size;
        w_signed = r_signed;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_rdata  = r_rdata;
        w_err    = r_err;
        case (r_state)
            IDLE: if (req_valid) begin
                w_write  = req_write;
                w_size   = req_size;
                w_signed = req_signed;
                // Forcing low bits is a no-op for aligned requests, so it is always applied
                w_addr   = req_addr & ~{{(ADDR_W-3){1'b0}}, w_lowmask};
                w_wdata  = req_wdata;
                w_rdata  = '0;
                w_err    = 1'b0;
                if (ALIGN_CHECK && w_mis) begin
                    w_next = RESP;
                    w_err  = 1'b1;
                end else
                    w_next = (req_write && req_size == 2'd3) ? WRITE : READ;
            end
            READ: if (mem_err) begin
                w_next  = RESP;
                w_err   = 1'b1;
                w_rdata = '0;
            end else if (r_write) begin
                w_next  = WRITE;
                w_wdata = w_merged;
            end else begin
                w_next  = RESP;
                w_rdata = w_ext;
            end
            WRITE: begin
                w_next  = RESP;
                w_err   = mem_err;
                w_rdata = '0;
            end
            default: if (resp_ready) w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_write  <= w_write;
            r_size   <= w_size;
            r_signed <= w_signed;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_rdata  <= w_rdata;
            r_err    <= w_err;
        end
    end
    assign req_ready         = r_state == IDLE;
    assign resp_valid        = r_state == RESP;
    assign resp_rdata        = resp_valid ? r_rdata : '0;
    assign resp_err          = resp_valid & r_err;
    assign mem_write_enabled = r_state == WRITE;
    assign mem_addr          = (r_state == READ || r_state == WRITE) ? {r_addr[ADDR_W-1:3], 3'b000} : '0;
    assign mem_w_data        = mem_write_enabled ? r_wdata : '0;
endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: directed self-checking bench for mem_request_unit
module tb_mem_request_unit;
    logic        clk = 0;
    logic        reset = 0;
    logic        req_valid = 0, req_write = 0, req_signed = 0, resp_ready = 0, mem_err = 0;
    logic [1:0]  req_size = 0;
    logic [63:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_err, mem_write_enabled;
    logic [63:0] resp_rdata, mem_addr, mem_w_data, mem_r_data;
    logic [63:0] mem [0:2047];
    int          n_rd = 0, n_wr = 0;
    logic [63:0] wr_addr, wr_data;
    int          checks = 0, errors = 0;
    int          lat, rd0, wr0;
    logic [63:0] rd;
    logic        er;

    mem_request_unit #(.ADDR_W(64), .ALIGN_CHECK(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_write_enabled(mem_write_enabled), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_r_data(mem_r_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    assign mem_r_data = mem[mem_addr[13:3]];

    always @(posedge clk) begin
        if (mem_write_enabled) begin
            mem[mem_addr[13:3]] = mem_w_data;
            n_wr    <= n_wr + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_w_data;
        end else if (mem_addr != 0)
            n_rd <= n_rd + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [63:0] a,
                          input logic [63:0] d, output int l, output logic [63:0] r, output logic e);
        @(negedge clk);
        req_valid = 1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1 req_valid = 0;
        l = 1;
        while (!resp_valid && l < 10) begin
            @(posedge clk);
            #1 l++;
        end
        r = resp_rdata;
        e = resp_err;
        resp_ready = 1;
        @(posedge clk);
        #1 resp_ready = 0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[11'h400] = 64'hF00DBEEF12348765;
        mem[11'h200] = 64'h1122334455667788;
        #12;
        check("rst_req_ready", {63'b0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", {63'b0, resp_err}, 64'd0);
        check("rst_mem_we", {63'b0, mem_write_enabled}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_w_data, 64'd0);
        @(negedge clk) reset = 1;

        do_req(0, 2'd0, 1, 64'h2001, 0, lat, rd, er);
        check("lb_data", rd, 64'hFFFFFFFFFFFFFF87);
        check("lb_err", {63'b0, er}, 64'd0);
        check("lb_lat", 64'(lat), 64'd2);
        do_req(0, 2'd1, 0, 64'h2006, 0, lat, rd, er);
        check("lhu_data", rd, 64'h000000000000F00D);
        do_req(0, 2'd2, 1, 64'h2004, 0, lat, rd, er);
        check("lw_data", rd, 64'hFFFFFFFFF00DBEEF);

        rd0 = n_rd; wr0 = n_wr;
        do_req(1, 2'd0, 0, 64'h1003, 64'hFFFFFFFFFFFFFFAB, lat, rd, er);
        check("sb_lat", 64'(lat), 64'd3);
        check("sb_err", {63'b0, er}, 64'd0);
        check("sb_rdata", rd, 64'd0);
        check("sb_reads", 64'(n_rd - rd0), 64'd1);
        check("sb_writes", 64'(n_wr - wr0), 64'd1);
        check("sb_wr_addr", wr_addr, 64'h1000);
        check("sb_wr_data", wr_data, 64'h11223344AB667788);
        do_req(0, 2'd3, 1, 64'h1000, 0, lat, rd, er);
        check("ld_after_sb", rd, 64'h11223344AB667788);

        rd0 = n_rd; wr0 = n_wr;
        do_req(1, 2'd3, 0, 64'h3000, 64'hDEADBEEFCAFEF00D, lat, rd, er);
        check("sd_lat", 64'(lat), 64'd2);
        check("sd_err", {63'b0, er}, 64'd0);
        check("sd_reads", 64'(n_rd - rd0), 64'd0);
        check("sd_writes", 64'(n_wr - wr0), 64'd1);
        check("sd_mem", mem[11'h600], 64'hDEADBEEFCAFEF00D);

        rd0 = n_rd; wr0 = n_wr;
        do_req(0, 2'd2, 0, 64'h2002, 0, lat, rd, er);
        check("mis_err", {63'b0, er}, 64'd1);
        check("mis_rdata", rd, 64'd0);
        check("mis_lat", 64'(lat), 64'd1);
        check("mis_writes", 64'(n_wr - wr0), 64'd0);
        check("mis_reads", 64'(n_rd - rd0), 64'd0);

        @(negedge clk);
        req_valid = 1; req_write = 0; req_size = 2'd2; req_signed = 0; req_addr = 64'h2000;
        @(posedge clk);
        #1 req_valid = 0;
        @(posedge clk);
        #1 check("stall_first", resp_rdata, 64'h0000000012348765);
        req_valid = 1; req_size = 2'd0; req_signed = 1; req_addr = 64'h2000;
        rd0 = n_rd;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {63'b0, resp_valid}, 64'd1);
            check("stall_rdata", resp_rdata, 64'h0000000012348765);
            check("stall_ready", {63'b0, req_ready}, 64'd0);
            check("stall_maddr", mem_addr, 64'd0);
            check("stall_mwe", {63'b0, mem_write_enabled}, 64'd0);
        end
        check("stall_no_read", 64'(n_rd - rd0), 64'd0);
        resp_ready = 1;
        @(posedge clk);
        #1 resp_ready = 0;
        check("hs_valid_drop", {63'b0, resp_valid}, 64'd0);
        check("hs_ready", {63'b0, req_ready}, 64'd1);
        @(posedge clk);
        #1 req_valid = 0;
        check("next_read_addr", mem_addr, 64'h2000);
        @(posedge clk);
        #1 check("next_rdata", resp_rdata, 64'h0000000000000065);
        resp_ready = 1;
        @(posedge clk);
        #1 resp_ready = 0;

        mem_err = 1;
        do_req(0, 2'd0, 1, 64'h2001, 0, lat, rd, er);
        check("merr_ld_err", {63'b0, er}, 64'd1);
        check("merr_ld_rdata", rd, 64'd0);
        wr0 = n_wr;
        do_req(1, 2'd0, 0, 64'h1000, 64'h55, lat, rd, er);
        check("merr_sb_err", {63'b0, er}, 64'd1);
        check("merr_sb_writes", 64'(n_wr - wr0), 64'd0);
        mem_err = 0;

        mem[11'h200] = 64'h1122334455667788;
        wr0 = n_wr;
        @(negedge clk);
        req_valid = 1; req_write = 1; req_size = 2'd0; req_signed = 0; req_addr = 64'h1003; req_wdata = 64'hCD;
        @(posedge clk);
        #1 req_valid = 0;
        check("rstop_in_read", mem_addr, 64'h1000);
        #1 reset = 0;
        #1;
        check("rstop_mwe", {63'b0, mem_write_enabled}, 64'd0);
        check("rstop_maddr", mem_addr, 64'd0);
        check("rstop_valid", {63'b0, resp_valid}, 64'd0);
        check("rstop_ready", {63'b0, req_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk) reset = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rstop_writes", 64'(n_wr - wr0), 64'd0);
        check("rstop_mem", mem[11'h200], 64'h1122334455667788);
        check("rstop_ready_after", {63'b0, req_ready}, 64'd1);
        check("rstop_valid_after", {63'b0, resp_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
Initiator for the simulated memory interface. It accepts load/store requests from the MEM pipeline stage over a valid/ready handshake and drives the 64-bit doubleword memory port (write enable, address, write data, read data, error). It handles byte, half, word and doubleword accesses with little-endian lane selection and load sign/zero extension. Sub-doubleword stores are performed as read-modify-write. It returns one response per request.

Parameters:
ADDR_W, 64, request and memory address width.
ALIGN_CHECK, 1, 1 = misaligned request returns an error with no memory cycle; 0 = low address bits below the size are forced to zero.

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset (0 = in reset)
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = doubleword
req_signed  in  1  loads: sign-extend when 1; ignored for stores and doubleword
req_addr  in  ADDR_W  byte address
req_wdata  in  64  store data, right-justified
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  64  extended load data; 0 for stores and errors
resp_err  out  1  misaligned request or memory error
mem_write_enabled  out  1  memory write strobe; write commits at posedge
mem_addr  out  ADDR_W  doubleword-aligned address, low 3 bits always 0
mem_w_data  out  64  full doubleword to write
mem_r_data  in  64  combinational read data, valid in the same cycle as mem_addr when not writing
mem_err  in  1  memory error, sampled with the read/write cycle

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE. req_ready = 1. resp_valid = 0, resp_rdata = 0, resp_err = 0. mem_write_enabled = 0, mem_addr = 0, mem_w_data = 0. All latched request fields clear.
- Reset mid-operation: mem_write_enabled drops immediately. No write commits. A pending response is discarded.
- FSM states: IDLE, READ, WRITE, RESP. Only one request is outstanding at a time.
- IDLE:
  - req_ready = 1; memory outputs = 0.
  - On req_valid, latch write, size, signed, addr and wdata. Lane = addr[2:0].
  - Next state:
    - misaligned (addr mod 2^size != 0) and ALIGN_CHECK = 1: RESP with err = 1.
    - load: READ.
    - doubleword store: WRITE with mem_w_data = wdata.
    - sub-doubleword store: READ.
- READ:
  - mem_write_enabled = 0; mem_addr = {addr[ADDR_W-1:3], 3'b0}. Sample mem_r_data and mem_err at the clock edge.
  - Load: extract bytes [lane .. lane + 2^size - 1], extend per req_signed, go to RESP.
  - Store: replace those bytes in the read doubleword with the low 2^size bytes of wdata, go to WRITE.
  - If mem_err is set: go straight to RESP with err = 1 and rdata = 0. A store with an error never writes.
- WRITE: mem_write_enabled = 1; mem_addr aligned; mem_w_data = merged/full data. The write commits at this edge. Go to RESP; err = mem_err.
- RESP:
  - resp_valid = 1; req_ready = 0. resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready, go to IDLE; resp_valid drops the next cycle. Back-to-back: the next request is accepted in the IDLE cycle after the handshake.
- Latency, from the acceptance edge to resp_valid high:
  - load or sub-doubleword store without error: 2 cycles (RMW store: 3).
  - doubleword store: 2 cycles.
  - misaligned: 1 cycle.
- Throughput: at most 1 request per 3 cycles (load), 4 cycles (RMW store).
- Width rules:
  - Byte lanes are little-endian (lane 0 = bits 7:0).
  - Doubleword loads ignore req_signed.
  - Unused high bits of req_wdata are ignored for sub-doubleword stores.
- Stalled response: request inputs are ignored while not in IDLE. The memory port is idle (mem_write_enabled = 0, mem_addr = 0).

Test Plan:
- Doubleword 0xF00DBEEF12348765 preloaded at 0x2000:
  - signed byte load at 0x2001 -> resp_rdata 0xFFFFFFFFFFFFFF87, err 0, resp_valid 2 cycles after accept.
  - unsigned half load at 0x2006 -> 0x000000000000F00D.
  - signed word load at 0x2004 -> 0xFFFFFFFFF00DBEEF.
- Memory 0x1000 = 0x1122334455667788:
  - byte store 0xAB at 0x1003 -> one read cycle then one write cycle at mem_addr 0x1000 with mem_w_data 0x11223344AB667788. A following doubleword load at 0x1000 returns that value.
  - doubleword store 0xDEADBEEFCAFEF00D at 0x3000 -> single write cycle, no read cycle, resp_err 0.
- Word load at 0x2002 with ALIGN_CHECK = 1 -> resp_err 1, resp_rdata 0, resp_valid 1 cycle after accept, mem_write_enabled never asserted.
- Hold resp_ready = 0 for 5 cycles after a load response -> resp_valid and resp_rdata stable, req_ready 0, memory port idle. A new request presented during the stall is accepted only after the handshake.
- Assert reset = 0 during the READ cycle of a byte store to 0x1003 -> outputs return to reset values immediately. Memory at 0x1000 is unchanged (0x1122334455667788). After release, req_ready = 1.
